// File: rtl/mcu0_pkg.sv
// Shared definitions for the mcu0 core: opcodes, ALU op codes and sequencer state encodings.
// Ports: none (package).
package mcu0_pkg;

  // IR[15:12] opcodes; 6..E decode as NOP.
  localparam logic [3:0] OpLd  = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpJmp = 4'h2;
  localparam logic [3:0] OpSt  = 4'h3;
  localparam logic [3:0] OpCmp = 4'h4;
  localparam logic [3:0] OpJeq = 4'h5;
  localparam logic [3:0] OpHlt = 4'hF;

  // ALU operation select.
  localparam logic [3:0] AluZero  = 4'h0;
  localparam logic [3:0] AluAdd   = 4'h1;
  localparam logic [3:0] AluCmp   = 4'hE;
  localparam logic [3:0] AluApass = 4'hF;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StMem    = 3'd3,
    StExec   = 3'd4,
    StHalt   = 3'd5,
    StFault  = 3'd6
  } state_e;

  // Opcodes that need a second memory access (operand load or store).
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OpLd) || (op == OpAdd) || (op == OpSt) || (op == OpCmp);
  endfunction

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op == OpJmp) || (op == OpJeq);
  endfunction

endpackage

// File: rtl/mcu0_ack_timer.sv
// Counts consecutive cycles a memory request waits without acknowledge.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   active         : request outstanding and not acknowledged this cycle
//   clear          : restart the count (ack or state change)
//   expire         : this waiting cycle is the Timeout-th consecutive one
module mcu0_ack_timer #(
  parameter int unsigned Timeout = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic active,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CntW = (Timeout < 2) ? 1 : $clog2(Timeout + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of earlier consecutive waiting cycles.
  assign expire = active && (cnt_q == CntW'(Timeout - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !active) begin
      cnt_d = '0;
    end else if (!expire) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mcu0_seq_ctrl.sv
// Multi-cycle sequencer for the mcu0 datapath. Steps each instruction through
// FETCH/DECODE/MEM/EXEC with a req/ack memory port, run/halt control, a retired
// instruction counter and a sticky memory-ack timeout fault.
// Ports:
//   clock, reset_n      : clock, async active-low reset
//   run                 : permission to start a new instruction (sampled at boundaries)
//   op, z               : IR[15:12] and equal flag
//   mem_ack             : memory completed the current request
//   mem_req, mem_we     : memory request / write
//   addr_sel            : 0 = PC, 1 = IR[11:0]
//   ir_w, pc_w, pcmux   : IR load, PC load, PC source (0 = PC+2, 1 = IR[11:0])
//   aw, sww, aluop      : A load, SW load, ALU operation
//   state               : current state (debug)
//   halted, fault       : sticky HLT executed / ack timeout
//   instret             : retired instruction count
module mcu0_seq_ctrl
  import mcu0_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [3:0]       op,
  input  logic             z,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_w,
  output logic             pc_w,
  output logic             pcmux,
  output logic             aw,
  output logic             sww,
  output logic [3:0]       aluop,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             count_inc;
  logic             expire;
  logic             waiting;

  // A request that is not acknowledged this cycle keeps the timer running.
  assign waiting = mem_req && !mem_ack;

  mcu0_ack_timer #(
    .Timeout (ACK_TIMEOUT)
  ) u_ack_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .active  (waiting),
    .clear   (mem_ack || (state_d != state_q)),
    .expire  (expire)
  );

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    count_inc = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_w      = 1'b0;
    pc_w      = 1'b0;
    pcmux     = 1'b0;
    aw        = 1'b0;
    sww       = 1'b0;
    aluop     = AluZero;

    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_w    = 1'b1;
          state_d = StDecode;
        end else if (expire) begin
          state_d = StFault;
        end
      end
      StDecode: begin
        pc_w = 1'b1;
        if (is_mem_op(op)) begin
          state_d = StMem;
        end else if (is_branch_op(op)) begin
          state_d = StExec;
        end else if (op == OpHlt) begin
          state_d   = StHalt;
          count_inc = 1'b1;
        end else begin
          retire = 1'b1;
        end
      end
      StMem: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op == OpSt);
        if (mem_ack) begin
          retire = 1'b1;
          case (op)
            OpLd: begin
              aw    = 1'b1;
              aluop = AluApass;
            end
            OpAdd: begin
              aw    = 1'b1;
              aluop = AluAdd;
            end
            OpCmp: begin
              sww   = 1'b1;
              aluop = AluCmp;
            end
            default: ;
          endcase
        end else if (expire) begin
          state_d = StFault;
        end
      end
      StExec: begin
        pcmux  = 1'b1;
        pc_w   = (op == OpJmp) || ((op == OpJeq) && z);
        retire = 1'b1;
      end
      StHalt, StFault: ;
      default: state_d = StIdle;
    endcase

    // run is only consulted here, so an instruction in flight always completes.
    if (retire) begin
      count_inc = 1'b1;
      state_d   = run ? StFetch : StIdle;
    end
  end

  assign instret_d = count_inc ? instret_q + CNT_W'(1) : instret_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == StHalt);
  assign fault   = (state_q == StFault);
  assign instret = instret_q;

endmodule

// File: tb/tb_mcu0_seq_ctrl.sv
// Directed bench for mcu0_seq_ctrl with hand-computed per-cycle expectations.
module tb_mcu0_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  op = 4'h0;
  logic        z = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_w, pc_w, pcmux, aw, sww;
  logic [3:0]  aluop;
  logic [2:0]  state;
  logic        halted, fault;
  logic [15:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mcu0_seq_ctrl #(
    .CNT_W       (16),
    .ACK_TIMEOUT (15)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .run      (run),
    .op       (op),
    .z        (z),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .addr_sel (addr_sel),
    .ir_w     (ir_w),
    .pc_w     (pc_w),
    .pcmux    (pcmux),
    .aw       (aw),
    .sww      (sww),
    .aluop    (aluop),
    .state    (state),
    .halted   (halted),
    .fault    (fault),
    .instret  (instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in cycle 0 (IDLE) with reset released and inputs low.
  task automatic do_reset();
    reset_n = 1'b0;
    run = 1'b0;
    op = 4'h0;
    z = 1'b0;
    mem_ack = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset while MEM waits on ack.
    do_reset();
    #1;
    check("rst state", 32'(state), 0);
    check("rst req", 32'(mem_req), 0);
    check("rst aluop", 32'(aluop), 0);
    check("rst instret", 32'(instret), 0);
    check("rst halted", 32'(halted), 0);
    check("rst fault", 32'(fault), 0);
    run = 1'b1; mem_ack = 1'b1; op = 4'h0;
    tick();                 // c1 FETCH
    tick(); mem_ack = 1'b0; // c2 DECODE
    tick(); #1;             // c3 MEM waiting
    check("t1 mem state", 32'(state), 3);
    check("t1 mem req", 32'(mem_req), 1);
    check("t1 mem aw", 32'(aw), 0);
    #1;
    reset_n = 1'b0;
    #1;
    check("t1 async state", 32'(state), 0);
    check("t1 async req", 32'(mem_req), 0);
    check("t1 async aw", 32'(aw), 0);
    tick(); #1;
    check("t1 next state", 32'(state), 0);
    check("t1 next instret", 32'(instret), 0);
    check("t1 next aw", 32'(aw), 0);

    // Test 2: LD then ADD with ack tied high; run drops during ADD.
    do_reset();
    run = 1'b1; mem_ack = 1'b1; op = 4'h0;
    #1;
    check("t2 c0 state", 32'(state), 0);
    check("t2 c0 req", 32'(mem_req), 0);
    tick(); #1;
    check("t2 c1 state", 32'(state), 1);
    check("t2 c1 ir_w", 32'(ir_w), 1);
    check("t2 c1 req", 32'(mem_req), 1);
    check("t2 c1 addr_sel", 32'(addr_sel), 0);
    tick(); #1;
    check("t2 c2 state", 32'(state), 2);
    check("t2 c2 pc_w", 32'(pc_w), 1);
    check("t2 c2 pcmux", 32'(pcmux), 0);
    check("t2 c2 ir_w", 32'(ir_w), 0);
    tick(); #1;
    check("t2 c3 state", 32'(state), 3);
    check("t2 c3 aw", 32'(aw), 1);
    check("t2 c3 aluop", 32'(aluop), 32'hF);
    check("t2 c3 addr_sel", 32'(addr_sel), 1);
    check("t2 c3 we", 32'(mem_we), 0);
    tick(); #1;
    check("t2 c4 state", 32'(state), 1);
    check("t2 c4 ir_w", 32'(ir_w), 1);
    check("t2 c4 instret", 32'(instret), 1);
    check("t2 c4 aluop", 32'(aluop), 0);
    tick(); op = 4'h1; run = 1'b0; #1;
    check("t2 c5 pc_w", 32'(pc_w), 1);
    tick(); #1;
    check("t2 c6 state", 32'(state), 3);
    check("t2 c6 aw", 32'(aw), 1);
    check("t2 c6 aluop", 32'(aluop), 1);
    tick(); #1;
    check("t2 c7 state", 32'(state), 0);
    check("t2 c7 instret", 32'(instret), 2);
    check("t2 c7 req", 32'(mem_req), 0);

    // Test 3: JEQ z=0, JEQ z=1, JMP z=0.
    do_reset();
    run = 1'b1; mem_ack = 1'b1; op = 4'h5; z = 1'b0;
    tick(); tick();
    tick(); #1;  // c3 EXEC
    check("t3 jeq0 state", 32'(state), 4);
    check("t3 jeq0 pc_w", 32'(pc_w), 0);
    check("t3 jeq0 pcmux", 32'(pcmux), 1);
    check("t3 jeq0 req", 32'(mem_req), 0);
    tick(); z = 1'b1; #1;  // c4 FETCH
    check("t3 c4 instret", 32'(instret), 1);
    tick();
    tick(); #1;  // c6 EXEC
    check("t3 jeq1 pc_w", 32'(pc_w), 1);
    check("t3 jeq1 pcmux", 32'(pcmux), 1);
    tick(); op = 4'h2; z = 1'b0;  // c7 FETCH
    tick();
    tick(); run = 1'b0; #1;  // c9 EXEC
    check("t3 jmp state", 32'(state), 4);
    check("t3 jmp pc_w", 32'(pc_w), 1);
    tick(); #1;
    check("t3 end state", 32'(state), 0);
    check("t3 end instret", 32'(instret), 3);

    // Test 4: ST with ack delayed three cycles.
    do_reset();
    run = 1'b1; mem_ack = 1'b1; op = 4'h3;
    tick();                 // c1 FETCH
    tick(); mem_ack = 1'b0; // c2 DECODE
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("t4 wait state", 32'(state), 3);
      check("t4 wait req", 32'(mem_req), 1);
      check("t4 wait we", 32'(mem_we), 1);
      check("t4 wait sel", 32'(addr_sel), 1);
      check("t4 wait aluop", 32'(aluop), 0);
    end
    tick(); mem_ack = 1'b1; run = 1'b0; #1;  // c6 ack
    check("t4 ack req", 32'(mem_req), 1);
    check("t4 ack we", 32'(mem_we), 1);
    check("t4 ack sel", 32'(addr_sel), 1);
    check("t4 ack aw", 32'(aw), 0);
    check("t4 ack sww", 32'(sww), 0);
    check("t4 ack aluop", 32'(aluop), 0);
    tick(); #1;
    check("t4 end state", 32'(state), 0);
    check("t4 end instret", 32'(instret), 1);
    check("t4 end we", 32'(mem_we), 0);

    // CMP: SW strobe with CMP aluop.
    do_reset();
    run = 1'b1; mem_ack = 1'b1; op = 4'h4;
    tick(); tick();
    tick(); run = 1'b0; #1;
    check("cmp sww", 32'(sww), 1);
    check("cmp aw", 32'(aw), 0);
    check("cmp aluop", 32'(aluop), 32'hE);
    check("cmp we", 32'(mem_we), 0);

    // Test 5a: ack never arrives in FETCH.
    do_reset();
    run = 1'b1; op = 4'h0;
    for (int c = 1; c <= 15; c++) begin
      tick(); #1;
      if (c == 14 || c == 15) begin
        check("t5 pre state", 32'(state), 1);
        check("t5 pre fault", 32'(fault), 0);
      end
    end
    tick(); #1;  // c16
    check("t5 fault", 32'(fault), 1);
    check("t5 state", 32'(state), 6);
    check("t5 req", 32'(mem_req), 0);
    for (int i = 0; i < 4; i++) begin
      tick(); run = ~run; mem_ack = ~mem_ack;
    end
    #1;
    check("t5 sticky fault", 32'(fault), 1);
    check("t5 sticky state", 32'(state), 6);
    do_reset();
    #1;
    check("t5 reset fault", 32'(fault), 0);

    // Test 5b: ack in the 15th waiting cycle wins; then a NOP retires.
    run = 1'b1; op = 4'h6;
    for (int c = 1; c <= 14; c++) tick();
    tick(); mem_ack = 1'b1; #1;  // c15
    check("t5b ir_w", 32'(ir_w), 1);
    tick(); run = 1'b0; #1;      // c16 DECODE
    check("t5b state", 32'(state), 2);
    check("t5b fault", 32'(fault), 0);
    tick(); #1;
    check("t5b nop state", 32'(state), 0);
    check("t5b nop instret", 32'(instret), 1);

    // Test 6: HLT.
    do_reset();
    run = 1'b1; mem_ack = 1'b1; op = 4'hF;
    tick(); tick();
    tick(); #1;
    check("t6 halted", 32'(halted), 1);
    check("t6 state", 32'(state), 5);
    check("t6 instret", 32'(instret), 1);
    check("t6 req", 32'(mem_req), 0);
    for (int i = 0; i < 4; i++) begin
      tick(); run = ~run;
    end
    #1;
    check("t6 sticky state", 32'(state), 5);
    check("t6 sticky instret", 32'(instret), 1);
    check("t6 sticky pc_w", 32'(pc_w), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
